// File: rtl/key_matrix_pkg.sv
// Shared types and helpers for the push-button matrix scanner.
package key_matrix_pkg;

  localparam int unsigned DEF_COLS           = 3;
  localparam int unsigned DEF_ROWS           = 4;
  localparam int unsigned DEF_SETTLE_CYC     = 4;
  localparam int unsigned DEF_DEBOUNCE_SCANS = 3;
  localparam int unsigned MAX_COLS           = 8;

  // One state per driven column; the scanner supports up to MAX_COLS columns.
  typedef enum logic [2:0] {
    SCAN_0, SCAN_1, SCAN_2, SCAN_3, SCAN_4, SCAN_5, SCAN_6, SCAN_7
  } scan_state_t;

  // Active-low one-cold column drive for state k.
  function automatic logic [MAX_COLS-1:0] scan_pattern(input scan_state_t k,
                                                       input int unsigned cols);
    if (32'(k) >= cols) return '1;
    return ~(MAX_COLS'(1) << k);
  endfunction

  function automatic int code_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key's frame-based debouncer: a debounced bit plus a consecutive-mismatch counter.
module key_debounce_cell
  import key_matrix_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample,
  input  logic raw,
  output logic state
);

  localparam int unsigned CW = code_width(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      state <= 1'b0;
    end else if (sample) begin
      if (raw == state) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_SCANS - 1)) begin
        state <= ~state;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_matrix_reader.sv
// Column scanner, row synchronizer, per-key debounce array and priority event picker
// delivering press/release events over a valid/ready handshake.
module key_matrix_reader
  import key_matrix_pkg::*;
#(
  parameter int unsigned COLS           = DEF_COLS,
  parameter int unsigned ROWS           = DEF_ROWS,
  parameter int unsigned SETTLE_CYC     = DEF_SETTLE_CYC,
  parameter int unsigned DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  localparam int unsigned NKEYS         = COLS * ROWS,
  localparam int unsigned CODE_W        = code_width(NKEYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ROWS-1:0]   i_rows,
  output logic [COLS-1:0]   o_scan,
  output logic [NKEYS-1:0]  o_key_state,
  output logic              o_evt_valid,
  input  logic              i_evt_ready,
  output logic [CODE_W-1:0] o_evt_code,
  output logic              o_evt_press
);

  localparam int unsigned TW = code_width(SETTLE_CYC);

  scan_state_t   state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          running;
  logic          slot_end;

  // running stays low for the cycle after reset release so the first edge drives SCAN_0.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    slot_end  = running && (timer == TW'(SETTLE_CYC - 1));
    if (!running) begin
      timer_nxt = '0;
    end else if (slot_end) begin
      timer_nxt = '0;
      state_nxt = (state == scan_state_t'(COLS - 1)) ? SCAN_0 : scan_state_t'(state + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      state   <= SCAN_0;
      timer   <= '0;
    end else begin
      running <= 1'b1;
      state   <= state_nxt;
      timer   <= timer_nxt;
    end
  end

  assign o_scan = running ? COLS'(scan_pattern(state, COLS)) : '1;

  logic [ROWS-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_rows;
      sync2 <= sync1;
    end
  end

  logic [NKEYS-1:0] key_state;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      key_debounce_cell #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .sample(slot_end && (state == scan_state_t'(c))),
        .raw   (~sync2[r]),
        .state (key_state[c*ROWS+r])
      );
    end
  end

  assign o_key_state = key_state;

  logic [NKEYS-1:0]  rep, diff, pick_mask;
  logic              pick_found, pick_press, evt_en;
  logic [CODE_W-1:0] pick_idx;

  always_comb begin
    diff       = key_state ^ rep;
    pick_found = 1'b0;
    pick_press = 1'b0;
    pick_idx   = '0;
    pick_mask  = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      if (diff[i] && !pick_found) begin
        pick_found   = 1'b1;
        pick_idx     = CODE_W'(i);
        pick_press   = key_state[i];
        pick_mask[i] = 1'b1;
      end
    end
    evt_en = !o_evt_valid || i_evt_ready;
  end

  // The picked bit differs from rep, so toggling it makes rep match the reported state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep         <= '0;
      o_evt_valid <= 1'b0;
      o_evt_code  <= '0;
      o_evt_press <= 1'b0;
    end else if (evt_en) begin
      if (pick_found) begin
        o_evt_valid <= 1'b1;
        o_evt_code  <= pick_idx;
        o_evt_press <= pick_press;
        rep         <= rep ^ pick_mask;
      end else begin
        o_evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_reader.sv
// Directed bench for key_matrix_reader: a pin model closes keys against the scan pattern.
module tb_key_matrix_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_rows;
  logic [2:0]  o_scan;
  logic [11:0] o_key_state;
  logic        o_evt_valid;
  logic        i_evt_ready;
  logic [3:0]  o_evt_code;
  logic        o_evt_press;

  logic [11:0] phys;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [3:0]  code;
    logic        press;
    int unsigned cyc;
  } evt_t;
  evt_t q[$];

  typedef struct {
    logic [11:0] ph;
    logic [11:0] exp_st;
    int unsigned n;
    logic [4:0]  e0;
    logic [4:0]  e1;
    logic        consec;
  } vec_t;
  vec_t tbl[8];

  key_matrix_reader #(
    .COLS(3), .ROWS(4), .SETTLE_CYC(4), .DEBOUNCE_SCANS(3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rows     (i_rows),
    .o_scan     (o_scan),
    .o_key_state(o_key_state),
    .o_evt_valid(o_evt_valid),
    .i_evt_ready(i_evt_ready),
    .o_evt_code (o_evt_code),
    .o_evt_press(o_evt_press)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_rows = '1;
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 4; r++)
        if (!o_scan[c] && phys[c*4+r]) i_rows[r] = 1'b0;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && o_evt_valid && i_evt_ready)
      q.push_back('{code: o_evt_code, press: o_evt_press, cyc: cyc});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] evt_at(input int unsigned i);
    if (q.size() > i) return {27'b0, q[i].code, q[i].press};
    return 32'hDEAD;
  endfunction

  function automatic vec_t mk(input logic [11:0] ph, input logic [11:0] st, input int unsigned n,
                              input logic [4:0] e0, input logic [4:0] e1, input logic consec);
    vec_t v;
    v.ph = ph; v.exp_st = st; v.n = n; v.e0 = e0; v.e1 = e1; v.consec = consec;
    return v;
  endfunction

  // Returns at the negedge just after SCAN_0 starts driving (first cycle of a frame).
  task automatic wait_frame_start();
    int unsigned n = 0;
    while (o_scan !== 3'b011 && n < 100) begin @(negedge clk); n++; end
    while (o_scan !== 3'b110 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL frame_sync: scan=%b not cycling within %0d cycles", o_scan, n);
    end
  endtask

  logic [2:0] pats[3];

  initial begin
    logic [3:0]  hc;
    logic        hp;
    logic        seen;
    int unsigned bad;
    int unsigned n;

    pats[0] = 3'b110; pats[1] = 3'b101; pats[2] = 3'b011;
    tbl[0] = mk(12'h020, 12'h020, 1, {4'd5, 1'b1},  5'h0,            1'b0);
    tbl[1] = mk(12'h000, 12'h000, 1, {4'd5, 1'b0},  5'h0,            1'b0);
    tbl[2] = mk(12'h208, 12'h208, 2, {4'd3, 1'b1},  {4'd9, 1'b1},   1'b0);
    tbl[3] = mk(12'h000, 12'h000, 2, {4'd3, 1'b0},  {4'd9, 1'b0},   1'b0);
    tbl[4] = mk(12'h050, 12'h050, 2, {4'd4, 1'b1},  {4'd6, 1'b1},   1'b1);
    tbl[5] = mk(12'h000, 12'h000, 2, {4'd4, 1'b0},  {4'd6, 1'b0},   1'b1);
    tbl[6] = mk(12'h801, 12'h801, 2, {4'd0, 1'b1},  {4'd11, 1'b1},  1'b0);
    tbl[7] = mk(12'h000, 12'h000, 2, {4'd0, 1'b0},  {4'd11, 1'b0},  1'b0);

    phys = '0;
    i_evt_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scan", o_scan, 3'b111);
    chk("rst_valid", o_evt_valid, 1'b0);
    chk("rst_key_state", o_key_state, 12'h000);
    chk("rst_code_press", {o_evt_code, o_evt_press}, 5'h00);

    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      chk($sformatf("scan_cyc%0d", i), o_scan, pats[(i / 4) % 3]);
    end

    for (int i = 0; i < 8; i++) begin
      wait_frame_start();
      phys = tbl[i].ph;
      q.delete();
      repeat (60) @(negedge clk);
      chk($sformatf("vec%0d_state", i), o_key_state, tbl[i].exp_st);
      chk($sformatf("vec%0d_count", i), q.size(), tbl[i].n);
      if (tbl[i].n >= 1) chk($sformatf("vec%0d_evt0", i), evt_at(0), tbl[i].e0);
      if (tbl[i].n >= 2) chk($sformatf("vec%0d_evt1", i), evt_at(1), tbl[i].e1);
      if (tbl[i].consec)
        chk($sformatf("vec%0d_gap", i), (q.size() >= 2) ? q[1].cyc - q[0].cyc : 32'hDEAD, 1);
    end

    q.delete();
    for (int f = 0; f < 10; f++) begin
      wait_frame_start();
      phys = (f % 2 == 0) ? 12'h004 : 12'h000;
    end
    wait_frame_start();
    phys = '0;
    repeat (48) @(negedge clk);
    chk("bounce_state", o_key_state, 12'h000);
    chk("bounce_events", q.size(), 0);

    for (int f = 0; f < 12; f++) begin
      wait_frame_start();
      phys = (f % 3 != 2) ? 12'h004 : 12'h000;
    end
    wait_frame_start();
    phys = '0;
    repeat (48) @(negedge clk);
    chk("two_frame_state", o_key_state, 12'h000);
    chk("two_frame_events", q.size(), 0);

    for (int f = 0; f < 3; f++) begin
      wait_frame_start();
      phys = 12'h004;
    end
    wait_frame_start();
    phys = '0;
    repeat (60) @(negedge clk);
    chk("three_frame_count", q.size(), 2);
    chk("three_frame_evt0", evt_at(0), {4'd2, 1'b1});
    chk("three_frame_evt1", evt_at(1), {4'd2, 1'b0});

    // Stall: key 7's press is loaded at once, its release and key 1's press queue behind it.
    q.delete();
    i_evt_ready = 1'b0;
    wait_frame_start();
    phys = 12'h080;
    seen = 1'b0; bad = 0; hc = '0; hp = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i == 120) phys = 12'h000;
      if (i == 240) phys = 12'h002;
      @(negedge clk);
      if (o_evt_valid) begin
        if (!seen) begin
          seen = 1'b1; hc = o_evt_code; hp = o_evt_press;
        end else if (o_evt_code !== hc || o_evt_press !== hp) begin
          bad++;
        end
      end
    end
    chk("stall_valid", o_evt_valid, 1'b1);
    chk("stall_payload", {hc, hp}, {4'd7, 1'b1});
    chk("stall_payload_changes", bad, 0);
    chk("stall_key_state", o_key_state, 12'h002);
    i_evt_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("stall_count", q.size(), 3);
    chk("stall_evt0", evt_at(0), {4'd7, 1'b1});
    chk("stall_evt1", evt_at(1), {4'd1, 1'b1});
    chk("stall_evt2", evt_at(2), {4'd7, 1'b0});
    chk("stall_drained", o_evt_valid, 1'b0);

    phys = '0;
    repeat (72) @(negedge clk);
    i_evt_ready = 1'b0;
    phys = 12'h400;
    n = 0;
    while (!o_evt_valid && n < 200) begin @(negedge clk); n++; end
    chk("midrst_valid_seen", o_evt_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", o_evt_valid, 1'b0);
    chk("midrst_scan", o_scan, 3'b111);
    chk("midrst_key_state", o_key_state, 12'h000);
    chk("midrst_code", o_evt_code, 4'd0);
    i_evt_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    @(posedge clk); #1;
    chk("midrst_scan_restart", o_scan, 3'b110);
    repeat (60) @(negedge clk);
    chk("midrst_count", q.size(), 1);
    chk("midrst_evt0", evt_at(0), {4'd10, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
